// File: rtl/alu_writeback.sv
// ============================================================================
// Module   : alu_writeback
// Purpose  : ALU result tagging, writeback queue, branch resolution and
//            optional result bypass.  An issued op is tagged for one cycle
//            while the ALU computes.  Its result is then either queued for
//            the register file or resolved as a compare-branch.
// Config   : define ALU_WB_BYPASS_EN to drive the o_fwd_* bypass outputs;
//            when it is undefined those outputs are tied to zero.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_writeback #(
  parameter int FIFO_DEPTH = 2
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_issue_valid,
  output logic        o_issue_ready,
  input  logic [4:0]  i_issue_rd,
  input  logic        i_issue_is_branch,
  input  logic        i_issue_br_ne,
  input  logic [31:0] i_issue_br_target,
  input  logic [31:0] i_alu_result,
  input  logic        i_alu_flag_equal,
  input  logic        i_alu_flag_notequal,
  output logic        o_wb_valid,
  output logic [4:0]  o_wb_rd,
  output logic [31:0] o_wb_data,
  input  logic        i_wb_ready,
  output logic        o_branch_taken,
  output logic [31:0] o_branch_target,
  output logic        o_fwd_valid,
  output logic [4:0]  o_fwd_rd,
  output logic [31:0] o_fwd_data
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W:0] DEPTH_OCC = (CNT_W + 1)'(FIFO_DEPTH);

  // Tag of the op whose result the ALU presents this cycle
  logic        tag_valid;
  logic [4:0]  tag_rd;
  logic        tag_is_branch;
  logic        tag_br_ne;
  logic [31:0] tag_target;

  // Writeback queue state
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic [4:0]       q_rd   [FIFO_DEPTH];
  logic [31:0]      q_data [FIFO_DEPTH];

  logic           issue_fire;
  logic           enq;
  logic           deq;
  logic [CNT_W:0] occupancy;

  // The tag in flight reserves a queue slot, so a full queue can never be
  // overrun.  A dequeue this cycle is deliberately not credited here, which
  // keeps the ready path free of i_wb_ready.
  assign occupancy     = {1'b0, count} + {{CNT_W{1'b0}}, tag_valid};
  assign o_issue_ready = (occupancy < DEPTH_OCC);
  assign issue_fire    = i_issue_valid && o_issue_ready;

  // Writes to x0 are dropped at the tag stage and never occupy the queue
  assign enq = tag_valid && !tag_is_branch && (tag_rd != 5'd0);
  assign deq = o_wb_valid && i_wb_ready;

  assign o_wb_valid = (count != '0);
  assign o_wb_rd    = q_rd[rd_ptr];
  assign o_wb_data  = q_data[rd_ptr];

  // Capture the issued op's bookkeeping; the tag lives for exactly one cycle
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      tag_valid     <= 1'b0;
      tag_rd        <= 5'd0;
      tag_is_branch <= 1'b0;
      tag_br_ne     <= 1'b0;
      tag_target    <= 32'd0;
    end else begin
      tag_valid <= issue_fire;
      if (issue_fire) begin
        tag_rd        <= i_issue_rd;
        tag_is_branch <= i_issue_is_branch;
        tag_br_ne     <= i_issue_br_ne;
        tag_target    <= i_issue_br_target;
      end
    end
  end

  // Queue pointers and occupancy; power-of-two depth wraps pointers naturally
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (enq) wr_ptr <= wr_ptr + 1'b1;
      if (deq) rd_ptr <= rd_ptr + 1'b1;
      case ({enq, deq})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Queue storage carries no reset; validity is tracked by count alone
  always_ff @(posedge i_clk) begin
    if (enq) begin
      q_rd[wr_ptr]   <= tag_rd;
      q_data[wr_ptr] <= i_alu_result;
    end
  end

  // Resolve compare-branches into a one-cycle pulse; the target holds between
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_branch_taken  <= 1'b0;
      o_branch_target <= 32'd0;
    end else begin
      o_branch_taken <= tag_valid && tag_is_branch &&
                        (tag_br_ne ? i_alu_flag_notequal : i_alu_flag_equal);
      if (tag_valid && tag_is_branch) begin
        o_branch_target <= tag_target;
      end
    end
  end

`ifdef ALU_WB_BYPASS_EN
  // Expose the result being computed so a dependent op need not wait for it
  assign o_fwd_valid = enq;
  assign o_fwd_rd    = tag_rd;
  assign o_fwd_data  = i_alu_result;
`else
  assign o_fwd_valid = 1'b0;
  assign o_fwd_rd    = 5'd0;
  assign o_fwd_data  = 32'd0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_alu_writeback.sv
// ============================================================================
// Module   : tb_alu_writeback
// Purpose  : Directed self-checking bench for alu_writeback (default depth 2).
//            Bypass expectations follow ALU_WB_BYPASS_EN if it is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_writeback;

  localparam int FIFO_DEPTH = 2;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic        i_issue_valid;
  logic        o_issue_ready;
  logic [4:0]  i_issue_rd;
  logic        i_issue_is_branch;
  logic        i_issue_br_ne;
  logic [31:0] i_issue_br_target;
  logic [31:0] i_alu_result;
  logic        i_alu_flag_equal;
  logic        i_alu_flag_notequal;
  logic        o_wb_valid;
  logic [4:0]  o_wb_rd;
  logic [31:0] o_wb_data;
  logic        i_wb_ready;
  logic        o_branch_taken;
  logic [31:0] o_branch_target;
  logic        o_fwd_valid;
  logic [4:0]  o_fwd_rd;
  logic [31:0] o_fwd_data;

  int vectors     = 0;
  int miscompares = 0;

  alu_writeback #(.FIFO_DEPTH(FIFO_DEPTH)) dut (
    .i_clk               (i_clk),
    .i_reset             (i_reset),
    .i_issue_valid       (i_issue_valid),
    .o_issue_ready       (o_issue_ready),
    .i_issue_rd          (i_issue_rd),
    .i_issue_is_branch   (i_issue_is_branch),
    .i_issue_br_ne       (i_issue_br_ne),
    .i_issue_br_target   (i_issue_br_target),
    .i_alu_result        (i_alu_result),
    .i_alu_flag_equal    (i_alu_flag_equal),
    .i_alu_flag_notequal (i_alu_flag_notequal),
    .o_wb_valid          (o_wb_valid),
    .o_wb_rd             (o_wb_rd),
    .o_wb_data           (o_wb_data),
    .i_wb_ready          (i_wb_ready),
    .o_branch_taken      (o_branch_taken),
    .o_branch_target     (o_branch_target),
    .o_fwd_valid         (o_fwd_valid),
    .o_fwd_rd            (o_fwd_rd),
    .o_fwd_data          (o_fwd_data)
  );

  always #5 i_clk = ~i_clk;

  // An enqueue while the queue is already full must never happen
  always @(negedge i_clk) begin
    if (!i_reset) begin
      assert (!(dut.enq && (int'(dut.count) == FIFO_DEPTH)))
      else begin
        miscompares++;
        $error("FAIL enq_full observed enqueue with count %0d required none", dut.count);
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic issue(input logic [4:0] rd, input logic br, input logic ne,
                       input logic [31:0] tgt);
    i_issue_valid     = 1'b1;
    i_issue_rd        = rd;
    i_issue_is_branch = br;
    i_issue_br_ne     = ne;
    i_issue_br_target = tgt;
  endtask

  task automatic alu(input logic [31:0] res, input logic eq, input logic ne);
    i_alu_result        = res;
    i_alu_flag_equal    = eq;
    i_alu_flag_notequal = ne;
  endtask

  task automatic idle();
    i_issue_valid = 1'b0;
  endtask

  task automatic check_fwd(input string tag, input logic [4:0] rd, input logic [31:0] data,
                           input logic live);
`ifdef ALU_WB_BYPASS_EN
    check({tag, "_v"}, {31'd0, o_fwd_valid}, {31'd0, live});
    if (live) begin
      check({tag, "_rd"}, {27'd0, o_fwd_rd}, {27'd0, rd});
      check({tag, "_d"}, o_fwd_data, data);
    end
`else
    check({tag, "_v"}, {31'd0, o_fwd_valid}, 32'd0);
    check({tag, "_rd"}, {27'd0, o_fwd_rd}, 32'd0);
    check({tag, "_d"}, o_fwd_data, 32'd0);
`endif
  endtask

  initial begin
    i_reset = 1'b1;
    i_wb_ready = 1'b1;
    idle();
    issue(5'd0, 1'b0, 1'b0, 32'd0);
    idle();
    alu(32'd0, 1'b0, 1'b0);

    // Reset state
    step();
    check("rst_wb_valid", {31'd0, o_wb_valid}, 32'd0);
    check("rst_br_taken", {31'd0, o_branch_taken}, 32'd0);
    check("rst_br_target", o_branch_target, 32'd0);
    check("rst_fwd_valid", {31'd0, o_fwd_valid}, 32'd0);
    check("rst_ready", {31'd0, o_issue_ready}, 32'd1);
    i_reset = 1'b0;
    step();

    // Simple write: rd=5, result 7, visible in N+2 for one cycle
    check("w1_ready", {31'd0, o_issue_ready}, 32'd1);
    issue(5'd5, 1'b0, 1'b0, 32'd0);
    step();
    idle();
    alu(32'h0000_0007, 1'b0, 1'b0);
    #1;
    check("w1_n1_wb", {31'd0, o_wb_valid}, 32'd0);
    check_fwd("w1_fwd", 5'd5, 32'h7, 1'b1);
    step();
    check("w1_n2_wb", {31'd0, o_wb_valid}, 32'd1);
    check("w1_n2_rd", {27'd0, o_wb_rd}, 32'd5);
    check("w1_n2_data", o_wb_data, 32'h7);
    step();
    check("w1_n3_wb", {31'd0, o_wb_valid}, 32'd0);

    // Bypass of rd=9 result 0x1234
    issue(5'd9, 1'b0, 1'b0, 32'd0);
    step();
    idle();
    alu(32'h0000_1234, 1'b0, 1'b0);
    #1;
    check_fwd("fwd9", 5'd9, 32'h1234, 1'b1);
    step();
    check("fwd9_wb_data", o_wb_data, 32'h1234);
    step();

    // Branch on equal, taken
    issue(5'd0, 1'b1, 1'b0, 32'h0000_1000);
    step();
    idle();
    alu(32'hAAAA_5555, 1'b1, 1'b0);
    #1;
    check("b1_n1_taken", {31'd0, o_branch_taken}, 32'd0);
    check_fwd("b1_fwd", 5'd0, 32'd0, 1'b0);
    step();
    check("b1_n2_taken", {31'd0, o_branch_taken}, 32'd1);
    check("b1_n2_target", o_branch_target, 32'h0000_1000);
    check("b1_n2_wb", {31'd0, o_wb_valid}, 32'd0);
    step();
    check("b1_n3_taken", {31'd0, o_branch_taken}, 32'd0);
    check("b1_n3_target", o_branch_target, 32'h0000_1000);

    // Branch on equal, not taken
    issue(5'd0, 1'b1, 1'b0, 32'h0000_1000);
    step();
    idle();
    alu(32'd0, 1'b0, 1'b1);
    step();
    check("b2_n2_taken", {31'd0, o_branch_taken}, 32'd0);
    check("b2_n2_wb", {31'd0, o_wb_valid}, 32'd0);
    step();

    // Branch on not-equal, taken
    issue(5'd0, 1'b1, 1'b1, 32'h0000_2000);
    step();
    idle();
    alu(32'd0, 1'b0, 1'b1);
    step();
    check("b3_n2_taken", {31'd0, o_branch_taken}, 32'd1);
    check("b3_n2_target", o_branch_target, 32'h0000_2000);
    step();
    check("b3_n3_taken", {31'd0, o_branch_taken}, 32'd0);
    check("b3_n3_target", o_branch_target, 32'h0000_2000);

    // Write to x0 is dropped
    issue(5'd0, 1'b0, 1'b0, 32'd0);
    step();
    idle();
    alu(32'hDEAD_BEEF, 1'b0, 1'b0);
    #1;
    check("x0_n1_ready", {31'd0, o_issue_ready}, 32'd1);
    step();
    check("x0_n2_wb", {31'd0, o_wb_valid}, 32'd0);
    check("x0_n2_ready", {31'd0, o_issue_ready}, 32'd1);
    step();

    // Back-to-back issues with the register file accepting every cycle
    issue(5'd6, 1'b0, 1'b0, 32'd0);
    step();
    issue(5'd7, 1'b0, 1'b0, 32'd0);
    alu(32'h66, 1'b0, 1'b0);
    #1;
    check("bb_n1_ready", {31'd0, o_issue_ready}, 32'd1);
    step();
    idle();
    alu(32'h77, 1'b0, 1'b0);
    check("bb_n2_rd", {27'd0, o_wb_rd}, 32'd6);
    check("bb_n2_data", o_wb_data, 32'h66);
    step();
    check("bb_n3_wb", {31'd0, o_wb_valid}, 32'd1);
    check("bb_n3_rd", {27'd0, o_wb_rd}, 32'd7);
    check("bb_n3_data", o_wb_data, 32'h77);
    step();
    check("bb_n4_wb", {31'd0, o_wb_valid}, 32'd0);

    // Backpressure: fill the queue, stall, then drain in order
    i_wb_ready = 1'b0;
    issue(5'd1, 1'b0, 1'b0, 32'd0);
    step();
    issue(5'd2, 1'b0, 1'b0, 32'd0);
    alu(32'h11, 1'b0, 1'b0);
    #1;
    check("bp_n1_ready", {31'd0, o_issue_ready}, 32'd1);
    step();
    idle();
    alu(32'h22, 1'b0, 1'b0);
    check("bp_n2_ready", {31'd0, o_issue_ready}, 32'd0);
    check("bp_n2_rd", {27'd0, o_wb_rd}, 32'd1);
    check("bp_n2_data", o_wb_data, 32'h11);
    step();
    check("bp_n3_ready", {31'd0, o_issue_ready}, 32'd0);
    check("bp_n3_rd", {27'd0, o_wb_rd}, 32'd1);
    check("bp_n3_data", o_wb_data, 32'h11);
    step();
    check("bp_n4_wb", {31'd0, o_wb_valid}, 32'd1);
    check("bp_n4_rd", {27'd0, o_wb_rd}, 32'd1);
    i_wb_ready = 1'b1;
    step();
    check("bp_n5_wb", {31'd0, o_wb_valid}, 32'd1);
    check("bp_n5_rd", {27'd0, o_wb_rd}, 32'd2);
    check("bp_n5_data", o_wb_data, 32'h22);
    check("bp_n5_ready", {31'd0, o_issue_ready}, 32'd1);
    step();
    check("bp_n6_wb", {31'd0, o_wb_valid}, 32'd0);
    check("bp_n6_ready", {31'd0, o_issue_ready}, 32'd1);

    // Reset with a queued write and a tag in flight
    i_wb_ready = 1'b0;
    issue(5'd3, 1'b0, 1'b0, 32'd0);
    step();
    issue(5'd4, 1'b0, 1'b0, 32'd0);
    alu(32'h33, 1'b0, 1'b0);
    step();
    idle();
    alu(32'h44, 1'b0, 1'b0);
    check("rm_pre_wb", {31'd0, o_wb_valid}, 32'd1);
    i_reset = 1'b1;
    #1;
    check("rm_wb", {31'd0, o_wb_valid}, 32'd0);
    check("rm_fwd", {31'd0, o_fwd_valid}, 32'd0);
    check("rm_ready", {31'd0, o_issue_ready}, 32'd1);
    step();
    i_reset = 1'b0;
    i_wb_ready = 1'b1;
    #1;
    check("rm_rel_ready", {31'd0, o_issue_ready}, 32'd1);
    check("rm_rel_wb", {31'd0, o_wb_valid}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("rm_post_wb", {31'd0, o_wb_valid}, 32'd0);
      check("rm_post_br", {31'd0, o_branch_taken}, 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Absolute time limit so the run always ends
  initial begin
    #100000;
    $display("FAIL timeout observed no completion required completion");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
